// File: rtl/i2c_init_seq.sv
// rtl/i2c_init_seq.sv - init-RAM table walker issuing I2C register writes
// Fetches 24-bit entries, handles end/delay markers, retries NACKs, reports done/error.
module i2c_init_seq #(
  parameter int DEPTH      = 512,
  parameter int MAX_RETRY  = 3,
  parameter int DELAY_UNIT = 50000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic [11:0]              ram_addr,
  input  logic [23:0]              ram_data,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [7:0]               cmd_dev,
  output logic [7:0]               cmd_reg,
  output logic [7:0]               cmd_data,
  input  logic                     xfer_done,
  input  logic                     xfer_nack,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [$clog2(DEPTH)-1:0] err_index
);

  localparam int IW = $clog2(DEPTH);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [3:0] {
    IDLE, FETCH, LATCH, DECODE, ISSUE, WAIT_XFER, DELAY, NEXT, FINISH, FAIL
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   ram_addr_q;
  logic [RW-1:0]   retry_q;
  logic [23:0]     entry_q;
  logic [31:0]     dly_q;
  logic            cmd_valid_q;
  logic [7:0]      cmd_dev_q;
  logic [7:0]      cmd_reg_q;
  logic [7:0]      cmd_data_q;
  logic            busy_q;
  logic            done_q;
  logic            error_q;
  logic [IW-1:0]   err_index_q;

  logic [31:0]     dly_load;
  logic [IW-1:0]   idx_inc;

  assign dly_load = 32'(entry_q[15:0]) * 32'(DELAY_UNIT);
  assign idx_inc  = idx_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      ram_addr_q  <= '0;
      retry_q     <= '0;
      entry_q     <= '0;
      dly_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_dev_q   <= '0;
      cmd_reg_q   <= '0;
      cmd_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_index_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            idx_q      <= '0;
            ram_addr_q <= '0;
            retry_q    <= '0;
            error_q    <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= FETCH;
          end
        end
        FETCH: state_q <= LATCH;
        LATCH: begin
          entry_q <= ram_data;
          state_q <= DECODE;
        end
        DECODE: begin
          if (entry_q[23:16] == 8'hFF) begin
            done_q  <= 1'b1;
            state_q <= FINISH;
          end else if (entry_q[23:16] == 8'hFE) begin
            // A zero-tick delay skips DELAY entirely so it costs no extra cycle
            if (dly_load == 32'd0) begin
              state_q <= NEXT;
            end else begin
              dly_q   <= dly_load;
              state_q <= DELAY;
            end
          end else begin
            cmd_dev_q   <= {entry_q[23:17], 1'b0};
            cmd_reg_q   <= entry_q[15:8];
            cmd_data_q  <= entry_q[7:0];
            cmd_valid_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= WAIT_XFER;
          end
        end
        WAIT_XFER: begin
          if (xfer_done) begin
            if (!xfer_nack) begin
              state_q <= NEXT;
            end else if (retry_q < RW'(MAX_RETRY)) begin
              retry_q     <= retry_q + 1'b1;
              cmd_valid_q <= 1'b1;
              state_q     <= ISSUE;
            end else begin
              err_index_q <= idx_q;
              error_q     <= 1'b1;
              state_q     <= FAIL;
            end
          end
        end
        DELAY: begin
          if (dly_q == 32'd1) begin
            state_q <= NEXT;
          end else begin
            dly_q <= dly_q - 32'd1;
          end
        end
        NEXT: begin
          retry_q <= '0;
          // Running off the end of the RAM is a normal completion, not an error
          if (idx_q == IW'(DEPTH - 1)) begin
            done_q  <= 1'b1;
            state_q <= FINISH;
          end else begin
            idx_q      <= idx_inc;
            ram_addr_q <= idx_inc;
            state_q    <= FETCH;
          end
        end
        FINISH: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        FAIL: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_addr  = 12'(ram_addr_q);
  assign cmd_valid = cmd_valid_q;
  assign cmd_dev   = cmd_dev_q;
  assign cmd_reg   = cmd_reg_q;
  assign cmd_data  = cmd_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_index = err_index_q;

endmodule

// File: tb/tb_i2c_init_seq.sv
// tb/tb_i2c_init_seq.sv - scoreboard bench for i2c_init_seq
// RAM model, I2C master model with NACK plan, command scoreboard and timing gaps.
module tb_i2c_init_seq;

  localparam int DU = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] ram_addr;
  logic [23:0] ram_data = '0;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_dev, cmd_reg, cmd_data;
  logic        xfer_done, xfer_nack;
  logic        busy, done, error;
  logic [8:0]  err_index;

  i2c_init_seq #(.DEPTH(512), .MAX_RETRY(3), .DELAY_UNIT(DU)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ram_addr(ram_addr), .ram_data(ram_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .xfer_done(xfer_done), .xfer_nack(xfer_nack),
    .busy(busy), .done(done), .error(error), .err_index(err_index)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] dev;
    logic [7:0] rg;
    logic [7:0] dat;
    logic       nack;
  } cmd_t;

  cmd_t        sb_q[$];
  logic [23:0] mem [512];
  int          rise_q[$];
  int          xd_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          rst_at_edge = 1'b0;
  int          lat = 3;
  int          stall_at = -1;
  int          done_cnt = 0;
  int          stall_seen = 0;
  int          stall_bad = 0;
  int          start_cyc = 0;

  int          pend;
  bit          pnack;
  bit          prev_valid;
  bit          prev_done;
  int          stall_left;
  logic [23:0] snap;
  cmd_t        e;

  always @(posedge clk) ram_data <= mem[ram_addr[8:0]];

  always @(posedge clk) begin
    cyc = cyc + 1;
    rst_at_edge = rst;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // I2C master model: ready/stall, handshake scoreboard, delayed done/nack
  initial begin
    pend = 0; pnack = 0; prev_valid = 0; prev_done = 0; stall_left = 0; snap = '0;
    cmd_ready = 1'b0; xfer_done = 1'b0; xfer_nack = 1'b0;
    forever begin
      @(negedge clk);
      xfer_done = 1'b0;
      xfer_nack = 1'b0;
      if (rst_at_edge) begin
        pend = 0;
        stall_left = 0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          xfer_done = 1'b1;
          xfer_nack = pnack;
          xd_q.push_back(cyc + 1);
        end
      end
      if (prev_done) check_eq("busy_after_done", 32'(busy), 32'd0);
      prev_done = done;
      if (done) done_cnt++;
      if (cmd_valid && !prev_valid) begin
        rise_q.push_back(cyc);
        if (rise_q.size() - 1 == stall_at) begin
          stall_left = 10;
          stall_seen = 0;
          snap = {cmd_dev, cmd_reg, cmd_data};
        end
      end
      prev_valid = cmd_valid;
      if (cmd_valid && stall_left > 0) begin
        cmd_ready = 1'b0;
        stall_left--;
        stall_seen++;
        if ({cmd_dev, cmd_reg, cmd_data} !== snap) stall_bad++;
      end else begin
        cmd_ready = 1'b1;
      end
      if (cmd_valid && cmd_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_extra_cmd", {8'h0, cmd_dev, cmd_reg, cmd_data}, 32'd0);
          pnack = 1'b0;
        end else begin
          e = sb_q.pop_front();
          check_eq("cmd_dev", 32'(cmd_dev), 32'(e.dev));
          check_eq("cmd_reg", 32'(cmd_reg), 32'(e.rg));
          check_eq("cmd_data", 32'(cmd_data), 32'(e.dat));
          pnack = e.nack;
        end
        pend = lat;
      end
    end
  end

  task automatic put_write(input int idx, input logic [7:0] dev, input logic [7:0] rg,
                           input logic [7:0] dat, input int nacks, input bit final_ack);
    cmd_t c;
    mem[idx] = {dev, rg, dat};
    c.dev = dev & 8'hFE;
    c.rg  = rg;
    c.dat = dat;
    c.nack = 1'b1;
    for (int i = 0; i < nacks; i++) sb_q.push_back(c);
    c.nack = 1'b0;
    if (final_ack) sb_q.push_back(c);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_rise", 32'(busy), 32'd1);
    check_eq("error_clr_on_start", 32'(error), 32'd0);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge clk);
    check_eq("walk_finished", 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check_eq({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    check_eq({tag, "_cmd_fields"}, {8'h0, cmd_dev, cmd_reg, cmd_data}, 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_error"}, 32'(error), 32'd0);
    check_eq({tag, "_err_index"}, 32'(err_index), 32'd0);
  endtask

  int base, xbase, d0;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 24'hFF0000;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Basic two-write table with terminator
    put_write(0, 8'h98, 8'h01, 8'h06, 0, 1);
    put_write(1, 8'h98, 8'hF4, 8'h80, 0, 1);
    mem[2] = 24'hFF0000;
    base = rise_q.size(); xbase = xd_q.size(); d0 = done_cnt;
    pulse_start();
    wait_idle(2000);
    check_eq("basic_done", 32'(done_cnt - d0), 32'd1);
    check_eq("basic_error", 32'(error), 32'd0);
    check_eq("basic_sb_empty", 32'(sb_q.size()), 32'd0);
    check_eq("start_to_valid", 32'(rise_q[base] - start_cyc), 32'd3);
    check_eq("done_to_next_valid", 32'(rise_q[base+1] - xd_q[xbase]), 32'd4);

    // Stall first command ten cycles
    put_write(0, 8'h98, 8'h01, 8'h06, 0, 1);
    put_write(1, 8'h98, 8'hF4, 8'h80, 0, 1);
    stall_at = rise_q.size(); stall_bad = 0; d0 = done_cnt;
    pulse_start();
    wait_idle(2000);
    stall_at = -1;
    check_eq("stall_cycles", 32'(stall_seen), 32'd10);
    check_eq("stall_fields_stable", 32'(stall_bad), 32'd0);
    check_eq("stall_sb_empty", 32'(sb_q.size()), 32'd0);
    check_eq("stall_done", 32'(done_cnt - d0), 32'd1);

    // Entry 1 NACKs twice then ACKs; odd dev byte must go out with bit 0 cleared
    put_write(0, 8'h98, 8'h01, 8'h06, 0, 1);
    put_write(1, 8'h99, 8'h10, 8'h22, 2, 1);
    base = rise_q.size(); d0 = done_cnt;
    pulse_start();
    wait_idle(2000);
    check_eq("retry_issues", 32'(rise_q.size() - base), 32'd4);
    check_eq("retry_done", 32'(done_cnt - d0), 32'd1);
    check_eq("retry_error", 32'(error), 32'd0);
    check_eq("retry_sb_empty", 32'(sb_q.size()), 32'd0);

    // Entry 2 always NACKs -> retry exhaustion
    put_write(0, 8'h98, 8'h01, 8'h06, 0, 1);
    put_write(1, 8'h98, 8'h02, 8'h07, 0, 1);
    put_write(2, 8'h5A, 8'h33, 8'h44, 4, 0);
    mem[3] = 24'hFF0000;
    d0 = done_cnt;
    pulse_start();
    wait_idle(2000);
    check_eq("fail_error", 32'(error), 32'd1);
    check_eq("fail_err_index", 32'(err_index), 32'd2);
    check_eq("fail_no_done", 32'(done_cnt - d0), 32'd0);
    check_eq("fail_sb_empty", 32'(sb_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("error_sticky", 32'(error), 32'd1);
    put_write(0, 8'h98, 8'h01, 8'h06, 0, 1);
    put_write(1, 8'h98, 8'h02, 8'h07, 0, 1);
    put_write(2, 8'h5A, 8'h33, 8'h44, 0, 1);
    pulse_start();
    wait_idle(2000);
    check_eq("recover_done", 32'(done_cnt - d0), 32'd1);
    check_eq("recover_error", 32'(error), 32'd0);

    // Delay entries: 3 ticks and zero ticks
    put_write(0, 8'h98, 8'h01, 8'h06, 0, 1);
    mem[1] = 24'hFE0003;
    put_write(2, 8'h98, 8'h02, 8'h07, 0, 1);
    mem[3] = 24'hFE0000;
    put_write(4, 8'h98, 8'h03, 8'h08, 0, 1);
    mem[5] = 24'hFF0000;
    base = rise_q.size(); xbase = xd_q.size(); d0 = done_cnt;
    pulse_start();
    wait_idle(2000);
    check_eq("delay_3tick_gap", 32'(rise_q[base+1] - xd_q[xbase]), 32'(8 + 3 * DU));
    check_eq("delay_zero_gap", 32'(rise_q[base+2] - xd_q[xbase+1]), 32'd8);
    check_eq("delay_done", 32'(done_cnt - d0), 32'd1);
    check_eq("delay_sb_empty", 32'(sb_q.size()), 32'd0);

    // Reset while the master is still working on the first command
    lat = 10;
    put_write(0, 8'h98, 8'h01, 8'h06, 0, 1);
    put_write(1, 8'h98, 8'h02, 8'h07, 0, 0);
    mem[2] = 24'hFF0000;
    d0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
    check_eq("rst_first_hs", 32'(sb_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midrst");
    repeat (12) @(negedge clk);
    check_eq("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    lat = 3;
    put_write(0, 8'h98, 8'h01, 8'h06, 0, 1);
    put_write(1, 8'h98, 8'h02, 8'h07, 0, 1);
    pulse_start();
    check_eq("restart_addr0", 32'(ram_addr), 32'd0);
    wait_idle(2000);
    check_eq("restart_done", 32'(done_cnt - d0), 32'd1);
    check_eq("restart_sb_empty", 32'(sb_q.size()), 32'd0);

    // Full table with no terminator ends after the last index
    lat = 1;
    for (int i = 0; i < 512; i++)
      put_write(i, 8'h21, 8'(i), 8'(i ^ 37), 0, 1);
    d0 = done_cnt;
    pulse_start();
    wait_idle(20000);
    check_eq("full_done", 32'(done_cnt - d0), 32'd1);
    check_eq("full_error", 32'(error), 32'd0);
    check_eq("full_sb_empty", 32'(sb_q.size()), 32'd0);
    check_eq("full_last_addr", 32'(ram_addr), 32'd511);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
